seg_scan_display: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment bank, using the calculator's 6-bit display code set.
- Double-buffers a packed digit word through a load handshake and commits it only at frame boundaries, so the display never tears.
- Scans one digit at a time with dead time, PWM brightness and optional leading-zero blanking.
- Sits between the calculator result/format logic and the board's segment/digit pins.

---
 rtl/seg_scan_display.sv | 157 +++++++++++++++
 tb/tb_seg_scan_display.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scanner for the calculator's 6-bit display codes.
// A load handshake double-buffers the digit word. The word is committed only at
// frame end, so a frame never shows a mix of old and new digits.
module seg_scan_display #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned BRIGHT_W       = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [6*DIGITS-1:0]    iDATA,
  input  logic                   iLOAD,
  output logic                   oREADY,
  input  logic                   iBLANK_LZ,
  input  logic [BRIGHT_W-1:0]    iBRIGHT,
  output logic [7:0]             oSEG,
  output logic [DIGITS-1:0]      oDIG,
  output logic                   oFRAME
);

  localparam int unsigned CODE_W = 6;
  localparam int unsigned DATA_W = CODE_W * DIGITS;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0]  SLOT_MAX = '1;
  localparam logic [IDX_W-1:0]  LAST_DIG = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? '1 : '0;

  logic [DIV_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic                pending;
  logic [DATA_W-1:0]   shadow;
  logic [DATA_W-1:0]   active;
  logic [DIGITS-1:0]   blank_mask;

  logic                frame_end_c;
  logic                enable_c;
  logic [BRIGHT_W-1:0] slot_level_c;
  logic [CODE_W-1:0]   cur_code_c;
  logic [7:0]          seg_c;
  logic [DIGITS-1:0]   dig_c;

  // Glyph for a decimal digit, segments gfedcba.
  function automatic logic [6:0] digit_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7C;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Display code to {dp,g,f,e,d,c,b,a}. Unused codes stay dark.
  function automatic logic [7:0] decode(input logic [CODE_W-1:0] code);
    logic [7:0] seg;
    seg = 8'h00;
    if (code <= 6'd9) begin
      seg = {1'b0, digit_glyph(code[3:0])};
    end else if (code == 6'd10) begin
      seg = 8'h40;
    end else if (code >= 6'd16 && code <= 6'd25) begin
      seg = {1'b1, digit_glyph(4'(code - 6'd16))};
    end
    return seg;
  endfunction

  // Mask the run of plain zeros from the top digit down; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] codes,
                                                input logic              en);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = '0;
    run = en;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (run && codes[CODE_W*i +: CODE_W] == '0) begin
        m[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return m;
  endfunction

  // Scan position, frame boundary and PWM enable
  always_comb begin
    frame_end_c  = (slot_cnt == SLOT_MAX) && (dig_idx == LAST_DIG);
    slot_level_c = slot_cnt[DIV_W-1 -: BRIGHT_W];
    enable_c     = (slot_cnt != '0) && (slot_level_c <= iBRIGHT);
    cur_code_c   = active[CODE_W*dig_idx +: CODE_W];
    seg_c        = 8'h00;
    dig_c        = '0;
    if (enable_c) begin
      dig_c = DIGITS'(1) << dig_idx;
      if (!blank_mask[dig_idx]) begin
        seg_c = decode(cur_code_c);
      end
    end
  end

  // Slot and digit counters
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_cnt == SLOT_MAX) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == LAST_DIG) ? '0 : dig_idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + DIV_W'(1);
    end
  end

  // Load capture into the shadow buffer, commit to the active buffer at frame end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pending    <= 1'b0;
      shadow     <= '1;
      active     <= '1;
      blank_mask <= '0;
    end else if (iLOAD && !pending) begin
      shadow  <= iDATA;
      pending <= 1'b1;
    end else if (frame_end_c && pending) begin
      active     <= shadow;
      blank_mask <= lz_mask(shadow, iBLANK_LZ);
      pending    <= 1'b0;
    end
  end

  assign oREADY = ~pending;

  // Registered pin drive, polarity applied last
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSEG   <= SEG_OFF;
      oDIG   <= DIG_OFF;
      oFRAME <= 1'b0;
    end else begin
      oSEG   <= seg_c ^ SEG_OFF;
      oDIG   <= dig_c ^ DIG_OFF;
      oFRAME <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with DIGITS=4, DIV_W=4, BRIGHT_W=2 (slot 16, frame 64).
module tb_seg_scan_display;

  logic        clk;
  logic        rst_n;
  logic [23:0] data;
  logic        load;
  logic        ready;
  logic        blz;
  logic [1:0]  bright;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       frame;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int          m_k;
  logic        m_pend;
  logic [23:0] m_shadow;
  logic [23:0] m_act;
  logic [3:0]  m_mask;

  int         lit_cnt[4];
  logic [7:0] seg_or[4];

  seg_scan_display #(
    .DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iLOAD(load), .oREADY(ready),
    .iBLANK_LZ(blz), .iBRIGHT(bright), .oSEG(seg), .oDIG(dig), .oFRAME(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] digit_tbl(input int n);
    case (n)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7C;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] glyph(input logic [5:0] c);
    int v;
    v = int'(c);
    if (v <= 9) return digit_tbl(v);
    if (v == 10) return 8'h40;
    if (v >= 16 && v <= 25) return digit_tbl(v - 16) | 8'h80;
    return 8'h00;
  endfunction

  // Digits above the most significant non-zero code are hidden (never digit 0).
  function automatic logic [3:0] lzmask(input logic [23:0] w, input logic en);
    int top;
    logic [3:0] m;
    top = 0;
    m   = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (w[6*i +: 6] != 6'd0) top = i;
    if (en)
      for (int i = 0; i < 4; i++)
        if (i > top) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_k      = 0;
    m_pend   = 1'b0;
    m_shadow = '1;
    m_act    = '1;
    m_mask   = 4'b0000;
  endtask

  // Expected pins after the edge, derived from the cycle count since reset release.
  task automatic model_step(output exp_t e);
    int ph, slot, d;
    logic lit;
    ph   = m_k % 64;
    slot = ph % 16;
    d    = ph / 16;
    lit  = (slot >= 1) && (slot < (int'(bright) + 1) * 4);
    e.dig   = lit ? ~(4'b0001 << d) : 4'b1111;
    e.seg   = (lit && !m_mask[d]) ? glyph(m_act[6*d +: 6]) : 8'h00;
    e.frame = (ph == 63);
    if (load && !m_pend) begin
      m_shadow = data;
      m_pend   = 1'b1;
    end else if (ph == 63 && m_pend) begin
      m_act  = m_shadow;
      m_mask = lzmask(m_shadow, blz);
      m_pend = 1'b0;
    end
    e.ready = !m_pend;
    m_k++;
  endtask

  task automatic tick();
    exp_t e;
    exp_t o;
    @(posedge clk);
    model_step(e);
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk("seg",   32'(seg),   32'(o.seg));
    chk("dig",   32'(dig),   32'(o.dig));
    chk("frame", 32'(frame), 32'(o.frame));
    chk("ready", 32'(ready), 32'(o.ready));
    for (int d = 0; d < 4; d++) begin
      if (!dig[d]) begin
        lit_cnt[d]++;
        seg_or[d] = seg_or[d] | seg;
      end
    end
  endtask

  task automatic window();
    for (int d = 0; d < 4; d++) begin
      lit_cnt[d] = 0;
      seg_or[d]  = 8'h00;
    end
    repeat (64) tick();
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = frame;
    end
    chk("frame_seen", 32'(seen), 32'd1);
  endtask

  task automatic frame_len(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cnt++;
      if (frame) break;
    end
    chk(tag, 32'(cnt), 32'd64);
  endtask

  task automatic load_word(input logic [23:0] w);
    data = w;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic expect_segs(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                             input logic [7:0] s1, input logic [7:0] s0);
    chk({tag, "_d3"}, 32'(seg_or[3]), 32'(s3));
    chk({tag, "_d2"}, 32'(seg_or[2]), 32'(s2));
    chk({tag, "_d1"}, 32'(seg_or[1]), 32'(s1));
    chk({tag, "_d0"}, 32'(seg_or[0]), 32'(s0));
  endtask

  task automatic expect_lit(input string tag, input int n);
    for (int d = 0; d < 4; d++) chk(tag, 32'(lit_cnt[d]), 32'(n));
  endtask

  initial begin
    rst_n  = 1'b1;
    load   = 1'b0;
    data   = '1;
    blz    = 1'b0;
    bright = 2'd3;
    model_reset();
    #1 rst_n = 1'b0;
    #8;
    chk("rst_seg",   32'(seg),   32'h00);
    chk("rst_dig",   32'(dig),   32'hF);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle: blank codes, frame pulse every 64 cycles
    frame_len("first_frame_len");
    window();
    expect_segs("idle", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("idle_frame_end", 32'(frame), 32'd1);

    // Plain digits at full brightness
    load_word({6'd3, 6'd2, 6'd1, 6'd0});
    chk("ready_after_load", 32'(ready), 32'd0);
    wait_frame();
    window();
    expect_segs("digits", 8'h4F, 8'h5B, 8'h06, 8'h3F);
    expect_lit("lit_full", 15);

    // Leading-zero blanking, with a dp digit
    blz = 1'b1;
    load_word({6'd0, 6'd0, 6'd17, 6'd5});
    wait_frame();
    window();
    expect_segs("lz", 8'h00, 8'h00, 8'h86, 8'h6D);
    load_word(24'd0);
    wait_frame();
    window();
    expect_segs("lz_zero", 8'h00, 8'h00, 8'h00, 8'h3F);

    // A second load while busy is dropped
    blz  = 1'b0;
    data = {6'd4, 6'd3, 6'd2, 6'd1};
    load = 1'b1;
    tick();
    data = {6'd9, 6'd9, 6'd9, 6'd9};
    tick();
    load = 1'b0;
    wait_frame();
    window();
    expect_segs("busy_drop", 8'h66, 8'h4F, 8'h5B, 8'h06);

    // Load on the frame-end cycle is shown one frame later
    repeat (63) tick();
    load_word({6'd10, 6'd12, 6'd16, 6'd7});
    chk("fe_load_ready", 32'(ready), 32'd0);
    window();
    expect_segs("fe_old", 8'h66, 8'h4F, 8'h5B, 8'h06);
    window();
    expect_segs("fe_new", 8'h40, 8'h00, 8'hBF, 8'h07);

    // Dimmest brightness
    bright = 2'd0;
    window();
    expect_lit("lit_dim", 3);
    expect_segs("dim", 8'h40, 8'h00, 8'hBF, 8'h07);

    // Reset mid-slot with a load pending
    bright = 2'd3;
    load_word({6'd1, 6'd1, 6'd1, 6'd1});
    repeat (4) tick();
    chk("pre_rst_lit", 32'(dig), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",   32'(seg),   32'h00);
    chk("mid_rst_dig",   32'(dig),   32'hF);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    model_reset();
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    frame_len("post_rst_frame_len");
    window();
    expect_segs("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("post_rst_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
